// File: rtl/key_conditioner.sv
// Push-button conditioner: per key 2-FF synchroniser, press/release debounce,
// one-cycle press strobe and auto-repeat while held. All outputs registered.
module key_conditioner #(
   parameter int NUM_KEYS       = 2,
   parameter bit KEY_ACTIVE_LOW = 1'b1,
   parameter int DEBOUNCE_CYC   = 1000000,
   parameter int HOLD_CYC       = 50000000,
   parameter int REPEAT_CYC     = 10000000
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_pulse,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_long
);

   localparam int MAX_DH  = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
   localparam int MAX_CYC = (MAX_DH > REPEAT_CYC) ? MAX_DH : REPEAT_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC);

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      DB_PRESS   = 3'd1,
      PRESSED    = 3'd2,
      REPEAT     = 3'd3,
      DB_RELEASE = 3'd4
   } state_t;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      logic             sync1_q, sync1_d;
      logic             sync2_q, sync2_d;
      logic             act;
      state_t           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             pulse_q, pulse_d;
      logic             level_q, level_d;
      logic             long_q, long_d;

      always_comb begin
         sync1_d = key_raw[i];
         sync2_d = sync1_q;
         // act is 1 while the synchronised key reads as pressed
         act     = sync2_q ^ KEY_ACTIVE_LOW;
         state_d = state_q;
         cnt_d   = cnt_q + 1'b1;
         pulse_d = 1'b0;
         level_d = level_q;
         long_d  = long_q;
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (act) state_d = DB_PRESS;
            end
            DB_PRESS: begin
               if (!act) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
                  level_d = 1'b1;
               end
            end
            PRESSED: begin
               if (!act) begin
                  state_d = DB_RELEASE;
                  cnt_d   = '0;
               end else if (cnt_q == HOLD_LAST) begin
                  state_d = REPEAT;
                  cnt_d   = '0;
                  pulse_d = 1'b1;
                  long_d  = 1'b1;
               end
            end
            REPEAT: begin
               if (!act) begin
                  state_d = DB_RELEASE;
                  cnt_d   = '0;
                  long_d  = 1'b0;
               end else if (cnt_q == RPT_LAST) begin
                  cnt_d   = '0;
                  pulse_d = 1'b1;
               end
            end
            DB_RELEASE: begin
               // A bounce back to pressed keeps level high and restarts the hold timer
               if (act) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == DB_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  level_d = 1'b0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
               long_d  = 1'b0;
            end
         endcase
      end

      always_ff @(posedge clk_50M or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q <= KEY_ACTIVE_LOW;
            sync2_q <= KEY_ACTIVE_LOW;
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
         end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
            long_q  <= long_d;
         end
      end

      assign key_pulse[i] = pulse_q;
      assign key_level[i] = level_q;
      assign key_long[i]  = long_q;
   end

endmodule
